// File: rtl/sync_filter_n_pkg.sv
// Shared constants and sizing helper for the sync_filter_n input conditioner.
package sync_filter_n_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Bits needed to hold values 0..value-1; use clog2(FILT_LEN+1) for a minimal CNT_W.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_filter_n_if.sv
// Pin-side bundle for sync_filter_n: raw asynchronous inputs in, conditioned level and edge events out.
interface sync_filter_n_if #(
    parameter int N = 1
);
    logic [N-1:0] in_data;
    logic [N-1:0] out_data;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] evt;
    logic         any_evt;

    modport master (
        output in_data,
        input  out_data, rise, fall, evt, any_evt
    );

    modport slave (
        input  in_data,
        output out_data, rise, fall, evt, any_evt
    );
endinterface

// File: rtl/sync_filter_n_ch.sv
// One conditioner channel: synchroniser chain, optional persistence filter, rise/fall detector.
module sync_filter_n_ch #(
    parameter int   STAGES   = 2,
    parameter logic DEF      = 1'b0,
    parameter int   FILT_LEN = 0,
    parameter int   CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              level;
    logic              hist_q;

    // in_i feeds only sync_q[0]; constrain that path as false-path / max-delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {STAGES{DEF}};
        else     sync_q <= {sync_q[STAGES-2:0], in_i};
    end

    if (FILT_LEN == 0) begin : g_bypass
        assign level = sync_q[STAGES-1];
    end else begin : g_filt
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;

        // Any sample back at the accepted level clears the count, so short runs leave no trace.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (sync_q[STAGES-1] != level_q) begin
                if (cnt_q == CNT_LAST) level_d = sync_q[STAGES-1];
                else                   cnt_d   = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                level_q <= DEF;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level = level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= DEF;
        else     hist_q <= level;
    end

    assign out_o  = level;
    assign rise_o = level & ~hist_q;
    assign fall_o = ~level & hist_q;

endmodule

// File: rtl/sync_filter_n.sv
// N-channel pin-boundary conditioner: per-channel sync/filter/edge detect plus selectable event output.
module sync_filter_n
    import sync_filter_n_pkg::*;
#(
    parameter int           N         = 1,
    parameter int           STAGES    = 2,
    parameter logic [N-1:0] DEF       = '0,
    parameter int           FILT_LEN  = 0,
    parameter int           CNT_W     = 8,
    parameter int           EDGE_MODE = EDGE_BOTH
) (
    input  logic           clk,
    input  logic           rst,
    sync_filter_n_if.slave bus
);

    if (N < 1) begin : g_err_n
        $error("sync_filter_n: N must be >= 1");
    end
    if (STAGES < 2) begin : g_err_stages
        $error("sync_filter_n: STAGES must be >= 2");
    end
    if (CNT_W < 1 || CNT_W > 31 || FILT_LEN < 0 ||
        longint'(FILT_LEN) >= (longint'(1) << CNT_W)) begin : g_err_cnt
        $error("sync_filter_n: FILT_LEN must be below 2**CNT_W");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_err_mode
        $error("sync_filter_n: EDGE_MODE must be 0, 1 or 2");
    end
    if ($bits(bus.in_data) != N) begin : g_err_bus
        $error("sync_filter_n: interface width differs from N");
    end

    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] evt;

    for (genvar i = 0; i < N; i++) begin : g_ch
        sync_filter_n_ch #(
            .STAGES   (STAGES),
            .DEF      (DEF[i]),
            .FILT_LEN (FILT_LEN),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_i   (bus.in_data[i]),
            .out_o  (level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    always_comb begin
        case (EDGE_MODE)
            EDGE_RISE: evt = rise;
            EDGE_FALL: evt = fall;
            default:   evt = rise | fall;
        endcase
    end

    assign bus.out_data = level;
    assign bus.rise     = rise;
    assign bus.fall     = fall;
    assign bus.evt      = evt;
    assign bus.any_evt  = |evt;

endmodule
